// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and helpers for the iterative multiplier
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } mult_state_t;

    // Widest operand container; operands are sign/zero-extended into it so one
    // helper serves every WIDTH up to 64.
    localparam int MAX_W = 128;

    // Number of RUN cycles needed to retire the whole multiplier.
    function automatic int steps_of(input int width, input int bpc);
        return width / bpc;
    endfunction

    // Step counter width able to hold 0..STEPS.
    function automatic int cnt_w_of(input int width, input int bpc);
        return $clog2((width / bpc) + 1);
    endfunction

    // Magnitude of an extended operand; the most negative W-bit value maps to
    // 2^(W-1), which still fits in W unsigned bits.
    function automatic logic [MAX_W-1:0] abs_of(input logic [MAX_W-1:0] value,
                                                input logic             is_signed);
        if (is_signed && value[MAX_W-1]) begin
            return (~value) + MAX_W'(1);
        end
        return value;
    endfunction

endpackage

// File: rtl/mult_step.sv
// rtl/mult_step.sv - combinational partial-product adder retiring BITS_PER_CYCLE multiplier bits
module mult_step
    import mult_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic [2*WIDTH-1:0]        i_acc,
    input  logic [2*WIDTH-1:0]        i_mcand,
    input  logic [BITS_PER_CYCLE-1:0] i_mplier_slice,
    output logic [2*WIDTH-1:0]        o_acc_next
);

    // Add the multiplicand shifted by each set bit position of the slice.
    always_comb begin
        o_acc_next = i_acc;
        for (int j = 0; j < BITS_PER_CYCLE; j++) begin
            if (i_mplier_slice[j]) begin
                o_acc_next = o_acc_next + (i_mcand << j);
            end
        end
    end

endmodule

// File: rtl/iter_mult_unit.sv
// rtl/iter_mult_unit.sv - iterative signed/unsigned multiplier with valid/ready handshakes and flush (option: MULT_EARLY_OUT_EN)
module iter_mult_unit
    import mult_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 is_unsign,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 busy
);

    localparam int STEPS = steps_of(WIDTH, BITS_PER_CYCLE);
    localparam int CNT_W = cnt_w_of(WIDTH, BITS_PER_CYCLE);
    localparam int PW    = 2 * WIDTH;

    mult_state_t          r_state;
    mult_state_t          w_state_next;
    logic                 r_sign;
    logic [PW-1:0]        r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [PW-1:0]        r_acc;
    logic [CNT_W-1:0]     r_cnt;
    logic [PW-1:0]        r_result;

    logic [MAX_W-1:0]     w_a_ext;
    logic [MAX_W-1:0]     w_b_ext;
    logic [MAX_W-1:0]     w_abs_a;
    logic [MAX_W-1:0]     w_abs_b;
    logic                 w_unused_hi;
    logic [PW-1:0]        w_acc_next;
    logic                 w_accept;
    logic                 w_last_step;
    logic                 w_early;

    assign w_a_ext = {{(MAX_W-WIDTH){a[WIDTH-1] & ~is_unsign}}, a};
    assign w_b_ext = {{(MAX_W-WIDTH){b[WIDTH-1] & ~is_unsign}}, b};
    assign w_abs_a = abs_of(w_a_ext, ~is_unsign);
    assign w_abs_b = abs_of(w_b_ext, ~is_unsign);
    // Upper bits of the magnitudes are always zero for legal widths.
    assign w_unused_hi = ^{w_abs_a[MAX_W-1:WIDTH], w_abs_b[MAX_W-1:WIDTH]};

    assign req_ready   = (r_state == IDLE) & ~flush;
    assign resp_valid  = (r_state == DONE);
    assign busy        = (r_state != IDLE);
    assign result      = r_result;
    assign w_accept    = req_valid & req_ready;
    assign w_last_step = (r_cnt == CNT_W'(STEPS - 1));

`ifdef MULT_EARLY_OUT_EN
    // Nothing left to add once the remaining multiplier bits are all zero.
    assign w_early = (r_mplier == '0);
`else
    assign w_early = 1'b0;
`endif

    mult_step #(
        .WIDTH          (WIDTH),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_step (
        .i_acc          (r_acc),
        .i_mcand        (r_mcand),
        .i_mplier_slice (r_mplier[BITS_PER_CYCLE-1:0]),
        .o_acc_next     (w_acc_next)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; flush overrides every transition.
    always_comb begin
        w_state_next = r_state;
        if (flush) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE: if (w_accept) w_state_next = RUN;
                RUN:  if (w_early || w_last_step) w_state_next = FIX;
                FIX:  w_state_next = DONE;
                DONE: if (resp_ready) w_state_next = IDLE;
                default: w_state_next = IDLE;
            endcase
        end
    end

    // Datapath: latch magnitudes on accept, shift-add in RUN, apply sign in FIX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sign   <= 1'b0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else if (!flush) begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_sign   <= ~is_unsign & (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_mcand  <= {{WIDTH{1'b0}}, w_abs_a[WIDTH-1:0]};
                        r_mplier <= w_abs_b[WIDTH-1:0];
                        r_acc    <= '0;
                        r_cnt    <= '0;
                    end
                end
                RUN: begin
                    if (!w_early) begin
                        r_acc    <= w_acc_next;
                        r_mcand  <= r_mcand << BITS_PER_CYCLE;
                        r_mplier <= r_mplier >> BITS_PER_CYCLE;
                        r_cnt    <= r_cnt + CNT_W'(1);
                    end
                end
                FIX: begin
                    r_result <= r_sign ? (~r_acc + PW'(1)) : r_acc;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iter_mult_unit.sv
// tb/tb_iter_mult_unit.sv - directed self-checking bench for iter_mult_unit
module tb_iter_mult_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic        is_unsign;
    logic [31:0] a;
    logic [31:0] b;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] result;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef MULT_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    iter_mult_unit #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .is_unsign  (is_unsign),
        .a          (a),
        .b          (b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .result     (result),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y, input logic uns);
        logic [63:0] ex;
        logic [63:0] ey;
        ex = uns ? {32'b0, x} : {{32{x[31]}}, x};
        ey = uns ? {32'b0, y} : {{32{y[31]}}, y};
        return ex * ey;
    endfunction

    task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic uns);
        int w;
        w = 0;
        while (!req_ready && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        a = ia; b = ib; is_unsign = uns; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        a = $urandom; b = $urandom; is_unsign = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_resp(output int lat);
        lat = 0;
        while (!resp_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_op(input logic [31:0] ia, input logic [31:0] ib, input logic uns,
                          output logic [63:0] res, output int lat);
        issue(ia, ib, uns);
        wait_resp(lat);
        res = result;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (result !== 64'h0) begin n_fail++; $display("FAIL reset_result: got %h expected 0", result); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_unsigned_max();
        logic [63:0] res;
        int lat;
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, res, lat);
        n_checks++; if (res !== 64'hFFFF_FFFE_0000_0001) begin n_fail++; $display("FAIL umax_result: got %h expected fffffffe00000001", res); end
        n_checks++; if (lat != 33) begin n_fail++; $display("FAIL umax_latency: got %0d expected 33", lat); end
    endtask

    task automatic test_signed();
        logic [63:0] res;
        int lat;
        run_op(32'h8000_0000, 32'h8000_0000, 1'b0, res, lat);
        n_checks++; if (res !== 64'h4000_0000_0000_0000) begin n_fail++; $display("FAIL s_minmin: got %h expected 4000000000000000", res); end
        run_op(32'hFFFF_FFFF, 32'h0000_0002, 1'b0, res, lat);
        n_checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFFE) begin n_fail++; $display("FAIL s_neg1x2: got %h expected fffffffffffffffe", res); end
        run_op(32'hFFFF_FFFF, 32'h0000_0002, 1'b1, res, lat);
        n_checks++; if (res !== 64'h0000_0001_FFFF_FFFE) begin n_fail++; $display("FAIL u_maxx2: got %h expected 00000001fffffffe", res); end
        run_op(32'h7FFF_FFFF, 32'h8000_0000, 1'b0, res, lat);
        n_checks++; if (res !== 64'hC000_0000_8000_0000) begin n_fail++; $display("FAIL s_maxmin: got %h expected c000000080000000", res); end
    endtask

    task automatic test_backpressure();
        int lat;
        issue(32'd12345, 32'd678, 1'b1);
        // resp_ready outside DONE must be ignored
        resp_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        resp_ready = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL bp_early_ready_busy: got %b expected 1", busy); end
        wait_resp(lat);
        n_checks++; if (lat != 28) begin n_fail++; $display("FAIL bp_latency: got %0d expected 28 after early resp_ready", lat); end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            n_checks++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid[%0d]: got %b expected 1", i, resp_valid); end
            n_checks++; if (result !== 64'd8369910) begin n_fail++; $display("FAIL bp_hold_result[%0d]: got %0d expected 8369910", i, result); end
            n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold_req_ready[%0d]: got %b expected 0", i, req_ready); end
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid: got %b expected 0", resp_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_release_busy: got %b expected 0", busy); end
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_req_ready: got %b expected 1", req_ready); end
    endtask

    task automatic test_flush();
        logic [63:0] res;
        int lat;
        int seen;
        issue(32'd100, 32'd100, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL fl_busy_before: got %b expected 1", busy); end
        flush = 1'b1; req_valid = 1'b1; a = 32'd9; b = 32'd9; is_unsign = 1'b1;
        #1;
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL fl_req_ready: got %b expected 0", req_ready); end
        @(posedge clk); #1;
        flush = 1'b0; req_valid = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL fl_busy_after: got %b expected 0", busy); end
        n_checks++; if (result !== 64'd8369910) begin n_fail++; $display("FAIL fl_result_kept: got %0d expected 8369910", result); end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (resp_valid || busy) seen++;
        end
        n_checks++; if (seen != 0) begin n_fail++; $display("FAIL fl_no_activity: got %0d active cycles expected 0", seen); end
        run_op(32'd7, 32'd6, 1'b1, res, lat);
        n_checks++; if (res !== 64'd42) begin n_fail++; $display("FAIL fl_next_op: got %0d expected 42", res); end
    endtask

    task automatic test_reset_mid();
        logic [63:0] res;
        int lat;
        issue(32'd1234, 32'd5678, 1'b0);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rm_req_ready: got %b expected 1", req_ready); end
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rm_resp_valid: got %b expected 0", resp_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rm_busy: got %b expected 0", busy); end
        n_checks++; if (result !== 64'h0) begin n_fail++; $display("FAIL rm_result: got %h expected 0", result); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(32'd3, 32'hFFFF_FFFB, 1'b0, res, lat);
        n_checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFF1) begin n_fail++; $display("FAIL rm_3xm5: got %h expected fffffffffffffff1", res); end
    endtask

    task automatic test_latency_edges();
        logic [63:0] res;
        int lat;
        run_op(32'h0123_4567, 32'd0, 1'b1, res, lat);
        n_checks++; if (res !== 64'h0) begin n_fail++; $display("FAIL lat_b0_result: got %h expected 0", res); end
        n_checks++; if (lat != (EARLY ? 2 : 33)) begin n_fail++; $display("FAIL lat_b0: got %0d expected %0d", lat, EARLY ? 2 : 33); end
        run_op(32'h0000_ABCD, 32'd1, 1'b0, res, lat);
        n_checks++; if (res !== 64'h0000_0000_0000_ABCD) begin n_fail++; $display("FAIL lat_b1_result: got %h expected abcd", res); end
        n_checks++; if (lat != (EARLY ? 3 : 33)) begin n_fail++; $display("FAIL lat_b1: got %0d expected %0d", lat, EARLY ? 3 : 33); end
        run_op(32'hDEAD_BEEF, 32'd0, 1'b0, res, lat);
        n_checks++; if (res !== 64'h0) begin n_fail++; $display("FAIL lat_negx0: got %h expected 0", res); end
    endtask

    task automatic test_random();
        logic [63:0] res;
        logic [63:0] exp_res;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        ru;
        int lat;
        for (int i = 0; i < 300; i++) begin
            ra = $urandom;
            rb = (i % 7 == 0) ? 32'($urandom_range(0, 255)) : $urandom;
            ru = 1'($urandom_range(0, 1));
            exp_res = ref_mul(ra, rb, ru);
            run_op(ra, rb, ru, res, lat);
            n_checks++; if (res !== exp_res) begin n_fail++; $display("FAIL rnd_result[%0d] a=%h b=%h u=%b: got %h expected %h", i, ra, rb, ru, res, exp_res); end
            n_checks++; if (EARLY ? (lat < 2 || lat > 33) : (lat != 33)) begin n_fail++; $display("FAIL rnd_latency[%0d]: got %0d expected %s", i, lat, EARLY ? "2..33" : "33"); end
        end
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
        is_unsign = 1'b0; a = '0; b = '0;
        test_reset();
        test_unsigned_max();
        test_signed();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_latency_edges();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
